debouncer: RTL and testbench
============================

# debouncer

Conditions WIDTH independent button/switch inputs that have already passed through the 2-flip-flop synchronizer, and removes mechanical bounce from each one. It produces a stable level per input plus single-cycle rising- and falling-edge strobes. It sits between the input synchronizer and the user logic that consumes button presses, such as mode FSMs and counters. One shared sample timer serves all bits; each bit has its own saturating pulse counter.

## Interface
- WIDTH, 1: number of independent inputs.
- SAMPLE_CNT_MAX, 25000: clk cycles per sample tick (≥1).
- PULSE_CNT_MAX, 150: consecutive high samples required to declare a press (≥1).
- clk  input  1  system clock; the only clock.
- rst_n  input  1  reset, asynchronous, active-low.
- glitchy_signal  input  WIDTH  synchronized but bouncy inputs, already in the clk domain.
- debounced_signal  output  WIDTH  stable level per bit.
- rising_pulse  output  WIDTH  one-cycle strobe when debounced_signal[i] goes 0→1.
- falling_pulse  output  WIDTH  one-cycle strobe when debounced_signal[i] goes 1→0.

## Operation
- Sample timer
  - Shared counter, width $clog2(SAMPLE_CNT_MAX), counts 0..SAMPLE_CNT_MAX-1 and wraps to 0.
  - sample_tick = (timer == SAMPLE_CNT_MAX-1), combinational, high for exactly one cycle per period.
  - With SAMPLE_CNT_MAX=1, sample_tick is high every cycle.
- Pulse counter, one per bit, width $clog2(PULSE_CNT_MAX+1):
  - glitchy_signal[i]==0: clear to 0 on the next edge, in any cycle, regardless of tick.
  - glitchy_signal[i]==1 && sample_tick && cnt<PULSE_CNT_MAX: increment.
  - glitchy_signal[i]==1 && cnt==PULSE_CNT_MAX: hold (saturate, never wraps).
  - Otherwise: hold.
- debounced_signal[i] = (cnt[i] == PULSE_CNT_MAX), decoded from the register.
- Edge detect:
  - prev[i] register samples debounced_signal[i] every cycle.
  - rising_pulse[i] = debounced[i] & ~prev[i].
  - falling_pulse[i] = ~debounced[i] & prev[i].
- Bits are fully independent except for the shared tick.
- A low glitch of even one cycle restarts the count. Press detection is therefore strict and release is immediate.

## Timing
- Reset (rst_n=0, asynchronous): timer, all pulse counters and all prev bits go to 0. debounced_signal, rising_pulse and falling_pulse are all 0 while rst_n is low.
- First sample_tick occurs in the SAMPLE_CNT_MAX-th cycle after rst_n deasserts, i.e. when timer==SAMPLE_CNT_MAX-1.
- Press latency, input held high from reset release: debounced_signal rises after exactly PULSE_CNT_MAX×SAMPLE_CNT_MAX rising clk edges. rising_pulse is high in that same cycle only.
- Press latency, input rising mid-period: counts only ticks where the input is high. The delay lies between (PULSE_CNT_MAX-1)×SAMPLE_CNT_MAX+1 and PULSE_CNT_MAX×SAMPLE_CNT_MAX edges.
- Release latency: the input sampled low at edge N clears the counter. debounced_signal falls after edge N, and falling_pulse is high for exactly that one cycle.
- Input low in the same cycle as sample_tick: clear wins, counter goes to 0.
- Input bouncing (low then high again): the counter restarts from 0 and no strobes are issued while debounced_signal stays 0.
- Reset asserted mid-press (debounced=1): outputs drop to 0 immediately with no falling_pulse. After release no rising_pulse appears until a full re-qualification completes.
- Strobes never overlap: rising_pulse[i] & falling_pulse[i] == 0 always.
- Strobes are never longer than one cycle.

## Test plan
Use SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, WIDTH=2 unless noted.

1. Reset values: hold rst_n=0 with glitchy_signal=2'b11 → all outputs 0. Assert rst_n asynchronously mid-cycle → outputs 0 before the next clk edge.
2. Clean press: glitchy_signal[0]=1 from reset release → debounced_signal[0] rises after edge 12. rising_pulse[0] is high for exactly one cycle at that edge. Bit 1 outputs stay 0.
3. Bounce: toggle glitchy_signal[0] 1/0 every 3 cycles for 40 cycles, then hold 1 → no strobes during the bounce. Exactly one rising_pulse arrives 9–12 edges after the final rise.
4. Release: from debounced=1, drive glitchy_signal[0]=0 for one cycle → debounced falls after the next edge with a single falling_pulse. Holding high again → re-qualification takes 9–12 edges.
5. Independence and saturation: press bit 1 only and hold for 100 cycles → debounced_signal=2'b10 throughout after qualification. Only one rising_pulse[1] occurs; the counter never wraps.
6. Reset mid-press plus SAMPLE_CNT_MAX=1/PULSE_CNT_MAX=1 config:
   - Assert rst_n=0 with debounced=1 → no falling_pulse is issued.
   - With the 1/1 config, the input high from reset release → debounced rises after edge 1.

Source files
------------

// File: rtl/debouncer_if.sv
// Button-conditioning bundle between the input synchronizer and the debouncer.
// The bench or upstream logic drives the master side, and the debouncer takes the slave side.
interface debouncer_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] glitchy_signal;
    logic [WIDTH-1:0] debounced_signal;
    logic [WIDTH-1:0] rising_pulse;
    logic [WIDTH-1:0] falling_pulse;

    modport master (
        output glitchy_signal,
        input  debounced_signal,
        input  rising_pulse,
        input  falling_pulse
    );

    modport slave (
        input  glitchy_signal,
        output debounced_signal,
        output rising_pulse,
        output falling_pulse
    );
endinterface

// File: rtl/debouncer.sv
// Multi-bit debouncer: one shared sample timer, one saturating pulse counter per bit,
// and edge strobes derived from the debounced level.
module debouncer #(
    parameter int WIDTH          = 1,
    parameter int SAMPLE_CNT_MAX = 25000,
    parameter int PULSE_CNT_MAX  = 150
) (
    input  logic        clk,
    input  logic        rst_n,
    debouncer_if.slave  bus
);

    localparam int TIMER_W = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
    localparam int CNT_W   = $clog2(PULSE_CNT_MAX + 1);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SAMPLE_CNT_MAX - 1);
    localparam logic [CNT_W-1:0]   CNT_SAT    = CNT_W'(PULSE_CNT_MAX);

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               sample_tick;
    logic [CNT_W-1:0]   cnt_q [WIDTH];
    logic [CNT_W-1:0]   cnt_d [WIDTH];
    logic [WIDTH-1:0]   debounced;
    logic [WIDTH-1:0]   prev_q;

    // With a one-cycle period the timer stays at 0 and the tick fires on every cycle.
    always_comb begin
        sample_tick = (timer_q == TIMER_LAST);
        timer_d     = sample_tick ? '0 : timer_q + TIMER_W'(1);
    end

    // A low sample always clears the count, even on a tick, so any glitch restarts qualification.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!bus.glitchy_signal[i]) begin
                cnt_d[i] = '0;
            end else if (sample_tick && (cnt_q[i] < CNT_SAT)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            debounced[i] = (cnt_q[i] == CNT_SAT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            prev_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            timer_q <= timer_d;
            prev_q  <= debounced;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.debounced_signal = debounced;
    assign bus.rising_pulse     = debounced & ~prev_q;
    assign bus.falling_pulse    = ~debounced & prev_q;

endmodule

// File: tb/tb_debouncer.sv
// Randomized bench for debouncer: a 2-bit 4/3 instance and a 1-bit 1/1 instance,
// checked every cycle against an edge-count arithmetic model.
module tb_debouncer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;

    debouncer_if #(.WIDTH(2)) ifA ();
    debouncer_if #(.WIDTH(1)) ifB ();

    debouncer #(.WIDTH(2), .SAMPLE_CNT_MAX(4), .PULSE_CNT_MAX(3)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifA)
    );

    debouncer #(.WIDTH(1), .SAMPLE_CNT_MAX(1), .PULSE_CNT_MAX(1)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifB)
    );

    always #5 clk = ~clk;

    // Model: e counts edges since reset release; a tick falls on every edge where e is a
    // multiple of the sample period. The level is high once enough ticks lie after the last low sample.
    int         e = 0;
    int         lastLowA [2] = '{0, 0};
    int         lastLowB = 0;
    logic [1:0] prevDebA = '0;
    logic       prevDebB = 1'b0;

    function automatic logic expDeb(input int edges, input int lastLow, input int s, input int p);
        return ((edges / s) - (lastLow / s)) >= p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e           <= 0;
            lastLowA[0] <= 0;
            lastLowA[1] <= 0;
            lastLowB    <= 0;
            prevDebA    <= '0;
            prevDebB    <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                prevDebA[i] <= expDeb(e, lastLowA[i], 4, 3);
                if (!ifA.glitchy_signal[i]) lastLowA[i] <= e + 1;
            end
            prevDebB <= expDeb(e, lastLowB, 1, 1);
            if (!ifB.glitchy_signal[0]) lastLowB <= e + 1;
            e <= e + 1;
        end
    end

    int riseCntA  [2] = '{0, 0};
    int fallCntA  [2] = '{0, 0};
    int riseEdgeA [2] = '{-1, -1};
    int riseCntB  = 0;
    int fallCntB  = 0;
    int riseEdgeB = -1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic compareAll();
        logic [1:0] dA, rA, fA;
        logic       dB, rB, fB;
        for (int i = 0; i < 2; i++) begin
            dA[i] = expDeb(e, lastLowA[i], 4, 3);
            rA[i] = dA[i] & ~prevDebA[i];
            fA[i] = ~dA[i] & prevDebA[i];
        end
        dB = expDeb(e, lastLowB, 1, 1);
        rB = dB & ~prevDebB;
        fB = ~dB & prevDebB;
        checkOutput("A_debounced", int'(ifA.debounced_signal), int'(dA));
        checkOutput("A_rising",    int'(ifA.rising_pulse),     int'(rA));
        checkOutput("A_falling",   int'(ifA.falling_pulse),    int'(fA));
        checkOutput("B_debounced", int'(ifB.debounced_signal), int'(dB));
        checkOutput("B_rising",    int'(ifB.rising_pulse),     int'(rB));
        checkOutput("B_falling",   int'(ifB.falling_pulse),    int'(fB));
        for (int i = 0; i < 2; i++) begin
            if (ifA.rising_pulse[i]) begin
                riseCntA[i]++;
                riseEdgeA[i] = e;
            end
            if (ifA.falling_pulse[i]) fallCntA[i]++;
        end
        if (ifB.rising_pulse[0]) begin
            riseCntB++;
            riseEdgeB = e;
        end
        if (ifB.falling_pulse[0]) fallCntB++;
    endtask

    task automatic waitCycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            compareAll();
        end
    endtask

    task automatic applyStimulus(input logic [1:0] a, input logic b, input int n);
        ifA.glitchy_signal = a;
        ifB.glitchy_signal = b;
        waitCycles(n);
    endtask

    initial begin
        int         eh, baseR, baseF, baseF1, baseFB, k, len;
        logic       level;
        logic [1:0] rndA;
        logic       rndB;

        // Reset held with inputs high
        rst_n = 1'b0;
        applyStimulus(2'b11, 1'b1, 3);
        checkOutput("reset_debounced", int'(ifA.debounced_signal), 0);
        checkOutput("reset_rising",    int'(ifA.rising_pulse),     0);
        checkOutput("reset_falling",   int'(ifA.falling_pulse),    0);
        checkOutput("reset_B_deb",     int'(ifB.debounced_signal), 0);

        // Clean press on bit 0 from reset release
        rst_n = 1'b1;
        applyStimulus(2'b01, 1'b1, 20);
        checkOutput("press_rise_edge",  riseEdgeA[0], 12);
        checkOutput("press_rise_count", riseCntA[0], 1);
        checkOutput("press_bit1_quiet", riseCntA[1], 0);
        checkOutput("press_level",      int'(ifA.debounced_signal), 1);
        checkOutput("B_rise_edge",      riseEdgeB, 1);

        // One-cycle release, then re-qualification
        applyStimulus(2'b00, 1'b1, 1);
        checkOutput("release_level", int'(ifA.debounced_signal[0]), 0);
        checkOutput("release_fall_count", fallCntA[0], 1);
        eh = e;
        applyStimulus(2'b01, 1'b1, 15);
        checkOutput("requal_rise_count", riseCntA[0], 2);
        checkOutput("requal_fall_count", fallCntA[0], 1);
        checkRange("requal_latency", riseEdgeA[0] - eh, 9, 12);

        // Random-length bounce, never high long enough to qualify
        applyStimulus(2'b00, 1'b1, 2);
        baseR = riseCntA[0];
        baseF = fallCntA[0];
        level = 1'b0;
        k = 0;
        while (k < 40) begin
            level = ~level;
            len = $urandom_range(1, 3);
            applyStimulus({1'b0, level}, 1'b1, len);
            k += len;
        end
        applyStimulus(2'b00, 1'b1, 1);
        checkOutput("bounce_no_rise", riseCntA[0], baseR);
        checkOutput("bounce_no_fall", fallCntA[0], baseF);
        eh = e;
        applyStimulus(2'b01, 1'b1, 15);
        checkOutput("bounce_one_rise", riseCntA[0], baseR + 1);
        checkRange("bounce_latency", riseEdgeA[0] - eh, 9, 12);

        // Bit 1 alone, held long enough to saturate
        applyStimulus(2'b10, 1'b1, 100);
        checkOutput("indep_rise1", riseCntA[1], 1);
        checkOutput("indep_fall1", fallCntA[1], 0);
        checkOutput("indep_level", int'(ifA.debounced_signal), 2);

        // Randomized inputs on both instances
        rndA = 2'b10;
        rndB = 1'b1;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 15) == 0) rndA[i] = ~rndA[i];
            end
            if ($urandom_range(0, 2) == 0) rndB = ~rndB;
            applyStimulus(rndA, rndB, 1);
        end

        // Asynchronous reset mid-cycle while both bits are pressed
        applyStimulus(2'b11, 1'b1, 20);
        checkOutput("pre_reset_level", int'(ifA.debounced_signal), 3);
        checkOutput("pre_reset_B",     int'(ifB.debounced_signal), 1);
        baseF  = fallCntA[0];
        baseF1 = fallCntA[1];
        baseFB = fallCntB;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_level",   int'(ifA.debounced_signal), 0);
        checkOutput("async_reset_falling", int'(ifA.falling_pulse),    0);
        checkOutput("async_reset_rising",  int'(ifA.rising_pulse),     0);
        checkOutput("async_reset_B",       int'(ifB.debounced_signal), 0);
        applyStimulus(2'b11, 1'b1, 3);
        checkOutput("reset_no_fall0", fallCntA[0], baseF);
        checkOutput("reset_no_fall1", fallCntA[1], baseF1);
        checkOutput("reset_no_fallB", fallCntB, baseFB);
        rst_n = 1'b1;
        applyStimulus(2'b11, 1'b1, 15);
        checkOutput("requal0_edge", riseEdgeA[0], 12);
        checkOutput("requal1_edge", riseEdgeA[1], 12);
        checkOutput("requalB_edge", riseEdgeB, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
